gate_model_bist: RTL and testbench

//  Parametrised built-in self-test wrapper for combinational gate-library models (GateModel netlists).
//  In functional mode the wrapper passes external inputs straight to the model.
//  In BIST mode an LFSR drives PATTERNS pseudo-random vectors into the model.
//  A MISR compacts the model outputs into a signature, which is compared against a golden value.
//  The wrapper instantiates next to the model in the lab simulator; model widths are set by parameter.

---
 rtl/gate_model_bist.sv | 114 +++++++++++
 tb/tb_gate_model_bist.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_model_bist.sv
// BIST wrapper for combinational gate-library models.
// LFSR drives the model while busy; a MISR compacts its outputs into a signature.
module gate_model_bist #(
  parameter int                N_IN      = 21,
  parameter int                N_OUT     = 10,
  parameter int                MISR_W    = 16,
  parameter int                PATTERNS  = 1024,
  parameter logic [N_IN-1:0]   LFSR_TAPS = 21'h140000,
  parameter logic [MISR_W-1:0] MISR_TAPS = 16'hB400,
  parameter int                SEED      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MISR_W-1:0] golden,
  input  logic [N_IN-1:0]   func_in,
  output logic [N_OUT-1:0]  func_out,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam int CW = $clog2(PATTERNS + 1);
  localparam logic [N_IN-1:0] SEED_V =
    (SEED == 0) ? N_IN'(1) : N_IN'(SEED);
  localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [N_IN-1:0]   lfsr;
  logic [MISR_W-1:0] misr;
  logic [CW-1:0]     cnt;
  logic [N_IN-1:0]   lfsr_n;
  logic [MISR_W-1:0] misr_n;

  assign lfsr_n = {lfsr[N_IN-2:0], ^(lfsr & LFSR_TAPS)};
  assign misr_n = {misr[MISR_W-2:0], ^(misr & MISR_TAPS)}
                ^ MISR_W'(dut_out);

  assign dut_in   = busy ? lfsr : func_in;
  assign func_out = dut_out;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_n = S_SEED;
      S_SEED: begin
        busy    = 1'b1;
        state_n = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr      <= SEED_V;
      misr      <= '0;
      cnt       <= '0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pass      <= 1'b0;
            signature <= '0;
          end
        end
        S_SEED: begin
          lfsr <= SEED_V;
          misr <= '0;
          cnt  <= '0;
        end
        S_RUN: begin
          lfsr <= lfsr_n;
          misr <= misr_n;
          cnt  <= cnt + CW'(1);
        end
        S_DONE: begin
          signature <= misr;
          pass      <= (misr == golden);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_model_bist.sv
// Directed bench: small 4-bit config with hand values,
// default config against a behavioural LFSR/MISR model.
module tb_gate_model_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // small configuration
  logic       rst_n_s, start_s, busy_s, done_s, pass_s;
  logic [3:0] golden_s, func_in_s, func_out_s;
  logic [3:0] dut_in_s, dut_out_s, sig_s;

  gate_model_bist #(
    .N_IN(4), .N_OUT(4), .MISR_W(4), .PATTERNS(4),
    .LFSR_TAPS(4'b1001), .MISR_TAPS(4'b1001), .SEED(1)
  ) u_s (
    .clk(clk), .rst_n(rst_n_s), .start(start_s),
    .golden(golden_s), .func_in(func_in_s),
    .func_out(func_out_s), .dut_in(dut_in_s),
    .dut_out(dut_out_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .signature(sig_s)
  );

  // default configuration
  logic        rst_n_d, start_d, busy_d, done_d, pass_d;
  logic [15:0] golden_d, sig_d;
  logic [20:0] func_in_d, dut_in_d;
  logic [9:0]  func_out_d, dut_out_d;

  function automatic logic [9:0] gm(input logic [20:0] x);
    logic [9:0] o;
    for (int i = 0; i < 10; i++)
      o[i] = (x[2*i] & x[2*i+1]) ^ x[20-i];
    return o;
  endfunction

  assign dut_out_d = gm(dut_in_d);

  gate_model_bist u_d (
    .clk(clk), .rst_n(rst_n_d), .start(start_d),
    .golden(golden_d), .func_in(func_in_d),
    .func_out(func_out_d), .dut_in(dut_in_d),
    .dut_out(dut_out_d), .busy(busy_d), .done(done_d),
    .pass(pass_d), .signature(sig_d)
  );

  function automatic logic [15:0] sig_model();
    logic [20:0] l;
    logic [15:0] m;
    l = 21'd1;
    m = '0;
    for (int i = 0; i < 1024; i++) begin
      m = {m[14:0], ^(m & 16'hB400)} ^ {6'b0, gm(l)};
      l = {l[19:0], ^(l & 21'h140000)};
    end
    return m;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit big, input int lim,
                           output int cyc, output int nb);
    cyc = 0;
    nb  = 0;
    while (!(big ? done_d : done_s) && cyc < lim) begin
      if (big ? busy_d : busy_s) nb++;
      tick();
      cyc++;
    end
    chk("done_seen", {31'b0, big ? done_d : done_s}, 1);
  endtask

  logic [3:0]  seq [4];
  logic [15:0] ref_d;
  logic [3:0]  sig1;
  int cyc, nb, n_done;

  initial begin
    seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    rst_n_s = 0; rst_n_d = 0;
    start_s = 0; start_d = 0;
    golden_s = 4'b1010; golden_d = '0;
    func_in_s = 4'b0110; func_in_d = '0;
    dut_out_s = 4'b0001;
    ref_d = sig_model();
    tick(); tick();
    rst_n_s = 1; rst_n_d = 1;

    chk("rst_busy", {31'b0, busy_s}, 0);
    chk("rst_done", {31'b0, done_s}, 0);
    chk("rst_pass", {31'b0, pass_s}, 0);
    chk("rst_sig", {28'b0, sig_s}, 0);
    chk("rst_mux", {28'b0, dut_in_s}, {28'b0, func_in_s});

    // T1/T2: exact dut_in sequence and done timing
    start_s = 1; tick(); start_s = 0;
    chk("t1_seed_busy", {31'b0, busy_s}, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t1_in%0d", i), {28'b0, dut_in_s},
          {28'b0, seq[i]});
    end
    tick();
    chk("t1_done_k6", {31'b0, done_s}, 1);
    tick();
    chk("t1_done_pulse", {31'b0, done_s}, 0);
    chk("t1_sig", {28'b0, sig_s}, 32'b1010);
    chk("t2_pass1", {31'b0, pass_s}, 1);

    golden_s = 4'b1011;
    start_s = 1; tick(); start_s = 0;
    chk("t2_clr_sig", {28'b0, sig_s}, 0);
    wait_done(0, 20, cyc, nb);
    tick();
    chk("t2_pass0", {31'b0, pass_s}, 0);
    chk("t2_sig", {28'b0, sig_s}, 32'b1010);

    // T3: zero response, busy window
    dut_out_s = 4'b0000;
    start_s = 1; tick(); start_s = 0;
    wait_done(0, 20, cyc, nb);
    chk("t3_cyc", cyc, 5);
    chk("t3_busy", nb, 5);
    tick();
    chk("t3_sig", {28'b0, sig_s}, 0);

    // T5: restarts ignored while busy and in DONE
    dut_out_s = 4'b0001;
    golden_s = 4'b1010;
    n_done = 0;
    start_s = 1; tick(); start_s = 0;
    for (int i = 0; i < 15; i++) begin
      start_s = (i == 3) || done_s;
      tick();
      if (done_s) n_done++;
    end
    start_s = 0;
    chk("t5_one_done", n_done, 1);
    chk("t5_idle", {31'b0, busy_s}, 0);
    chk("t5_sig", {28'b0, sig_s}, 32'b1010);

    // T5: start held high, back-to-back runs
    start_s = 1;
    wait_done(0, 20, cyc, nb);
    tick();
    sig1 = sig_s;
    wait_done(0, 20, cyc, nb);
    chk("t5_b2b_gap", cyc, 6);
    tick();
    start_s = 0;
    chk("t5_b2b_sig1", {28'b0, sig1}, 32'b1010);
    chk("t5_b2b_same", {28'b0, sig_s}, {28'b0, sig1});

    // T6: functional passthrough, default config
    func_in_d = 21'h15555;
    #1;
    chk("t6_mux", {11'b0, dut_in_d}, 32'h15555);
    chk("t6_fout", {22'b0, func_out_d},
        {22'b0, gm(21'h15555)});

    // T4: full default run, abort, rerun
    golden_d = ref_d;
    start_d = 1; tick(); start_d = 0;
    wait_done(1, 2000, cyc, nb);
    chk("t4_cyc", cyc, 1025);
    chk("t4_busy", nb, 1025);
    tick();
    chk("t4_sig", {16'b0, sig_d}, {16'b0, ref_d});
    chk("t4_pass", {31'b0, pass_d}, 1);

    start_d = 1; tick(); start_d = 0;
    repeat (10) tick();
    chk("t4_mid_busy", {31'b0, busy_d}, 1);
    rst_n_d = 0; tick(); rst_n_d = 1;
    chk("t4_abort_busy", {31'b0, busy_d}, 0);
    chk("t4_abort_sig", {16'b0, sig_d}, 0);
    chk("t4_abort_pass", {31'b0, pass_d}, 0);
    chk("t4_abort_mux", {11'b0, dut_in_d}, 32'h15555);

    start_d = 1; tick(); start_d = 0;
    wait_done(1, 2000, cyc, nb);
    tick();
    chk("t4_rerun_sig", {16'b0, sig_d}, {16'b0, ref_d});
    chk("t4_rerun_pass", {31'b0, pass_d}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
